// File: rtl/uart_seg7_scan_if.sv
// uart_seg7_scan_if: received-byte strobe bundle from the UART RX
// into the 7-segment scan controller.
interface uart_seg7_scan_if;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output rx_valid,
    output rx_data
  );

  modport slave (
    input rx_valid,
    input rx_data
  );
endinterface

// File: rtl/uart_seg7_scan.sv
// uart_seg7_scan: UART byte stream to a 4-digit multiplexed
// 7-segment display, edit buffer committed on CR/LF.
module uart_seg7_scan #(
  parameter int SCAN_CYCLES = 6750,
  parameter int DEAD_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_seg7_scan_if.slave  rx,
  output logic [6:0]       seg,
  output logic [3:0]       dig_en,
  output logic             err,
  output logic             ovf
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [15:0] ALL_BLANK = 16'hFFFF;

  logic [3:0][3:0] editBuf;
  logic [3:0][3:0] editNext;
  logic [3:0][3:0] dispBuf;
  logic [3:0][3:0] dispNext;
  logic [2:0]      editCnt;
  logic [2:0]      cntNext;
  logic            errNext;
  logic            ovfNext;
  logic [CW-1:0]   slotCnt;
  logic [1:0]      digIdx;
  logic [7:0]      rxByte;
  logic            isDigit;
  logic            isCommit;
  logic            isBack;
  logic            isEsc;
  logic            slotEnd;
  logic            slotLive;

  function automatic logic [6:0] segMap(input logic [3:0] code);
    case (code)
      4'd0:    segMap = 7'h3F;
      4'd1:    segMap = 7'h09;
      4'd2:    segMap = 7'h5E;
      4'd3:    segMap = 7'h5B;
      4'd4:    segMap = 7'h69;
      4'd5:    segMap = 7'h73;
      4'd6:    segMap = 7'h77;
      4'd7:    segMap = 7'h19;
      4'd8:    segMap = 7'h7F;
      4'd9:    segMap = 7'h7B;
      default: segMap = 7'h00;
    endcase
  endfunction

  assign rxByte   = rx.rx_data;
  assign slotEnd  = slotCnt == SLOT_LAST;
  assign slotLive = slotCnt >= SLOT_DEAD;

  // 0x08 is backspace, so it is excluded from the raw-digit range
  always_comb begin
    isBack   = rxByte == 8'h08;
    isCommit = (rxByte == 8'h0D) || (rxByte == 8'h0A);
    isEsc    = rxByte == 8'h1B;
    isDigit  = !isBack &&
               (((rxByte >= 8'h30) && (rxByte <= 8'h39)) ||
                (rxByte <= 8'h09));
  end

  always_comb begin
    editNext = editBuf;
    dispNext = dispBuf;
    cntNext  = editCnt;
    errNext  = 1'b0;
    ovfNext  = 1'b0;
    if (rx.rx_valid) begin
      unique case (1'b1)
        isBack: begin
          if (editCnt != 3'd0) begin
            editNext = {4'hF, editBuf[3:1]};
            cntNext  = editCnt - 3'd1;
          end
        end
        isDigit: begin
          editNext = {editBuf[2:0], rxByte[3:0]};
          if (editCnt == 3'd4) ovfNext = 1'b1;
          else cntNext = editCnt + 3'd1;
        end
        isCommit: begin
          dispNext = editBuf;
          editNext = ALL_BLANK;
          cntNext  = 3'd0;
        end
        isEsc: begin
          editNext = ALL_BLANK;
          cntNext  = 3'd0;
        end
        default: errNext = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      editBuf <= ALL_BLANK;
      dispBuf <= ALL_BLANK;
      editCnt <= 3'd0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      slotCnt <= '0;
      digIdx  <= 2'd0;
      dig_en  <= 4'b0000;
      seg     <= 7'h00;
    end else begin
      editBuf <= editNext;
      dispBuf <= dispNext;
      editCnt <= cntNext;
      err     <= errNext;
      ovf     <= ovfNext;
      slotCnt <= slotEnd ? '0 : slotCnt + 1'b1;
      if (slotEnd) digIdx <= digIdx + 2'd1;
      // seg and enable share one edge so no stale pattern leaks
      dig_en  <= slotLive ? (4'b0001 << digIdx) : 4'b0000;
      seg     <= slotLive ? segMap(dispBuf[digIdx]) : 7'h00;
    end
  end

endmodule

// File: tb/tb_uart_seg7_scan.sv
// tb_uart_seg7_scan: directed bytes, per-cycle reference model
// plus literal slot/segment expectations.
module tb_uart_seg7_scan;

  localparam int SCAN = 20;
  localparam int DEAD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic       err;
  logic       ovf;

  int nChecks = 0;
  int nFail = 0;
  int errSeen = 0;
  int ovfSeen = 0;

  int         q[$];
  int         disp[4];
  int         t;
  logic [6:0] eSeg;
  logic [3:0] eDig;
  logic       eErr;
  logic       eOvf;

  uart_seg7_scan_if rxIf();

  uart_seg7_scan #(
    .SCAN_CYCLES(SCAN),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx(rxIf),
    .seg(seg),
    .dig_en(dig_en),
    .err(err),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h, expected %0h",
               nm, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] segOf(input int c);
    case (c)
      0: return 7'h3F;
      1: return 7'h09;
      2: return 7'h5E;
      3: return 7'h5B;
      4: return 7'h69;
      5: return 7'h73;
      6: return 7'h77;
      7: return 7'h19;
      8: return 7'h7F;
      9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  task automatic modelReset();
    q.delete();
    for (int j = 0; j < 4; j++) disp[j] = 15;
    t = 0;
    eSeg = 7'h00;
    eDig = 4'b0000;
    eErr = 1'b0;
    eOvf = 1'b0;
  endtask

  // entered digits kept oldest-first; display slot j is j-th newest
  task automatic modelByte(input logic [7:0] b);
    if (b == 8'h08) begin
      if (q.size() > 0) void'(q.pop_back());
    end else if ((b >= 8'h30 && b <= 8'h39) || b <= 8'h09) begin
      if (q.size() == 4) begin
        void'(q.pop_front());
        eOvf = 1'b1;
      end
      q.push_back(int'(b[3:0]));
    end else if (b == 8'h0D || b == 8'h0A) begin
      for (int j = 0; j < 4; j++)
        disp[j] = (j < q.size()) ? q[q.size() - 1 - j] : 15;
      q.delete();
    end else if (b == 8'h1B) begin
      q.delete();
    end else begin
      eErr = 1'b1;
    end
  endtask

  initial begin
    int pos;
    int idx;
    modelReset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        modelReset();
      end else begin
        pos = t % SCAN;
        idx = (t / SCAN) % 4;
        eErr = 1'b0;
        eOvf = 1'b0;
        if (pos >= DEAD) begin
          eDig = 4'b0001 << idx;
          eSeg = segOf(disp[idx]);
        end else begin
          eDig = 4'b0000;
          eSeg = 7'h00;
        end
        if (rxIf.rx_valid) modelByte(rxIf.rx_data);
        t++;
      end
      #1;
      chk("model_seg", int'(seg), int'(eSeg));
      chk("model_dig_en", int'(dig_en), int'(eDig));
      chk("model_err", int'(err), int'(eErr));
      chk("model_ovf", int'(ovf), int'(eOvf));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      errSeen += int'(err);
      ovfSeen += int'(ovf);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic sendByte(input logic [7:0] b);
    rxIf.rx_valid = 1'b1;
    rxIf.rx_data  = b;
    @(negedge clk);
    rxIf.rx_valid = 1'b0;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  task automatic checkSlot(input logic [3:0] d, input int s,
                           input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < 6 * SCAN && !hit; i++) begin
      @(negedge clk);
      if (dig_en == d) hit = 1'b1;
    end
    if (!hit) chk({nm, "_wait"}, 0, 1);
    else chk(nm, int'(seg), s);
  endtask

  initial begin
    int onCnt[4];
    int first[4];
    int segOn;
    int e0;
    int o0;
    rxIf.rx_valid = 1'b0;
    rxIf.rx_data  = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", int'(seg), 0);
    chk("rst_dig_en", int'(dig_en), 0);
    reset_n = 1'b1;

    // idle scan: enable order, width and first assertion edge
    segOn = 0;
    for (int k = 0; k < 4; k++) begin
      onCnt[k] = 0;
      first[k] = -1;
    end
    for (int i = 0; i < 4 * SCAN; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (dig_en[k]) begin
          onCnt[k]++;
          if (first[k] < 0) first[k] = i;
        end
      end
      if (seg != 7'h00) segOn++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("idle_en_width", onCnt[k], SCAN - DEAD);
      chk("idle_en_first", first[k], k * SCAN + DEAD);
    end
    chk("idle_seg_zero", segOn, 0);

    e0 = errSeen;
    o0 = ovfSeen;
    sendStr("1234");
    sendByte(8'h0D);
    checkSlot(4'b0001, 'h69, "c1234_d0");
    checkSlot(4'b0010, 'h5B, "c1234_d1");
    checkSlot(4'b0100, 'h5E, "c1234_d2");
    checkSlot(4'b1000, 'h09, "c1234_d3");
    chk("c1234_err", errSeen - e0, 0);
    chk("c1234_ovf", ovfSeen - o0, 0);

    sendByte(8'h05);
    sendByte("6");
    sendByte(8'h08);
    sendByte("7");
    sendByte(8'h0A);
    checkSlot(4'b0001, 'h19, "bs_d0");
    checkSlot(4'b0010, 'h73, "bs_d1");
    checkSlot(4'b0100, 'h00, "bs_d2");
    checkSlot(4'b1000, 'h00, "bs_d3");

    e0 = errSeen;
    o0 = ovfSeen;
    sendStr("12345");
    sendByte(8'h0D);
    checkSlot(4'b0001, 'h73, "ovf_d0");
    checkSlot(4'b1000, 'h5E, "ovf_d3");
    chk("ovf_pulses", ovfSeen - o0, 1);
    chk("ovf_err", errSeen - e0, 0);

    e0 = errSeen;
    sendStr("9A");
    sendByte(8'h0D);
    checkSlot(4'b0001, 'h7B, "err_d0");
    checkSlot(4'b0010, 'h00, "err_d1");
    chk("err_pulses", errSeen - e0, 1);

    sendStr("9");
    sendByte(8'h1B);
    sendByte(8'h0D);
    checkSlot(4'b0001, 'h00, "esc_d0");
    checkSlot(4'b0010, 'h00, "esc_d1");

    // async reset in slot 2 with a partial edit pending
    sendStr("888");
    sendByte(8'h0D);
    sendStr("123");
    checkSlot(4'b0100, 'h7F, "prerst_d2");
    sendByte("Z");
    chk("prerst_err", int'(err), 1);
    reset_n = 1'b0;
    #1;
    chk("arst_seg", int'(seg), 0);
    chk("arst_dig_en", int'(dig_en), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_ovf", int'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sendByte(8'h0D);
    checkSlot(4'b0001, 'h00, "postrst_d0");
    checkSlot(4'b0010, 'h00, "postrst_d1");
    checkSlot(4'b0100, 'h00, "postrst_d2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
